cr_stats_evt_aggregator: RTL and testbench

CR_STATS_EVT_AGGREGATOR -- requirements
Module: cr_stats_evt_aggregator

---
 rtl/cr_stats_evt_aggregator_if.sv | 31 +++
 rtl/cr_stats_evt_aggregator.sv | 176 +++++++++++++++++
 tb/tb_cr_stats_evt_aggregator.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/cr_stats_evt_aggregator_if.sv
// Bundle of event, clear and read signals for the stats event aggregator.
interface cr_stats_evt_aggregator_if #(
    parameter int unsigned NUM_CNTR = 16,
    parameter int unsigned CNT_W    = 32
);
    localparam int unsigned AddrW = $clog2(NUM_CNTR) + 1;

    logic             evt_valid;
    logic [9:0]       evt_code;
    logic             evt_ready;
    logic             clr_all;
    logic             busy;
    logic             rd_req;
    logic [AddrW-1:0] rd_addr;
    logic             rd_clr;
    logic             rd_ack;
    logic [CNT_W-1:0] rd_data;
    logic             rd_err;
    logic [15:0]      oow_cnt;
    logic             oow_flag;

    modport master (
        output evt_valid, evt_code, clr_all, rd_req, rd_addr, rd_clr,
        input  evt_ready, busy, rd_ack, rd_data, rd_err, oow_cnt, oow_flag
    );

    modport slave (
        input  evt_valid, evt_code, clr_all, rd_req, rd_addr, rd_clr,
        output evt_ready, busy, rd_ack, rd_data, rd_err, oow_cnt, oow_flag
    );
endinterface

// File: rtl/cr_stats_evt_aggregator.sv
// Stats event aggregator: buffers event codes in a small FIFO, counts codes that fall in a
// window of local counters, tracks out-of-window codes, and serves counter reads with
// optional clear-on-read. A clear-all request sweeps the counters to zero one per cycle.
module cr_stats_evt_aggregator #(
    parameter int unsigned BASE_CODE  = 640,
    parameter int unsigned NUM_CNTR   = 16,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input logic                       clk,
    input logic                       rst,
    cr_stats_evt_aggregator_if.slave  bus
);
    localparam int unsigned IdxW  = (NUM_CNTR > 1) ? $clog2(NUM_CNTR) : 1;
    localparam int unsigned AddrW = $clog2(NUM_CNTR) + 1;
    localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned WinHi = BASE_CODE + NUM_CNTR;
    localparam logic [AddrW-1:0] NumCntrA = AddrW'(NUM_CNTR);
    localparam logic [IdxW-1:0]  LastIdx  = IdxW'(NUM_CNTR - 1);
    localparam logic [CNT_W-1:0] CntMax   = '1;

    typedef enum logic [0:0] {StIdle, StSweep} state_e;

    state_e state_q, state_d;
    logic [IdxW-1:0] sweep_idx_q, sweep_idx_d;

    logic [9:0]      fifo_q [FIFO_DEPTH];
    logic [PtrW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

    logic [CNT_W-1:0] cnt_q [NUM_CNTR];
    logic [CNT_W-1:0] cnt_d [NUM_CNTR];

    logic [15:0]      oow_cnt_q, oow_cnt_d;
    logic             oow_flag_q, oow_flag_d;
    logic             rd_ack_q, rd_ack_d, rd_err_q, rd_err_d;
    logic [CNT_W-1:0] rd_data_q, rd_data_d;

    logic            fifo_empty, fifo_full, push, pop, evt_ready, busy;
    logic [31:0]     head_ext, head_off;
    logic            in_win;
    logic [IdxW-1:0] pop_idx, rd_idx;
    logic            rd_ok, sweep_last;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                        (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    assign push       = bus.evt_valid && evt_ready;
    // Pop decision uses pre-edge occupancy; a push in the same cycle never bypasses.
    assign pop        = (state_q == StIdle) && !fifo_empty;

    assign head_ext = {22'd0, fifo_q[rd_ptr_q[PtrW-1:0]]};
    assign head_off = head_ext - BASE_CODE;
    assign in_win   = (head_ext >= BASE_CODE) && (head_ext < WinHi);
    assign pop_idx  = head_off[IdxW-1:0];

    assign rd_idx     = bus.rd_addr[IdxW-1:0];
    assign rd_ok      = bus.rd_req && (bus.rd_addr < NumCntrA) && (state_q == StIdle);
    assign sweep_last = (sweep_idx_q == LastIdx);

    // FSM state register and sweep index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            sweep_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            sweep_idx_q <= sweep_idx_d;
        end
    end

    // FSM next state: a clear request starts a sweep that visits every counter once.
    always_comb begin
        state_d     = state_q;
        sweep_idx_d = '0;
        unique case (state_q)
            StIdle: begin
                if (bus.clr_all) state_d = StSweep;
            end
            StSweep: begin
                if (sweep_last) state_d = StIdle;
                else            sweep_idx_d = sweep_idx_q + 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs: events are held off while sweeping and while reset is asserted.
    always_comb begin
        busy      = (state_q == StSweep);
        evt_ready = !rst && !fifo_full && (state_q == StIdle);
    end

    // FIFO pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // FIFO pointer advance.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    // FIFO storage; contents are only meaningful between the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q[PtrW-1:0]] <= bus.evt_code;
    end

    // Counter update: increment, then clear-on-read, then sweep (they never overlap a sweep).
    always_comb begin
        cnt_d = cnt_q;
        if (pop && in_win && (cnt_q[pop_idx] != CntMax)) begin
            cnt_d[pop_idx] = cnt_q[pop_idx] + CNT_W'(1);
        end
        if (rd_ok && bus.rd_clr) begin
            cnt_d[rd_idx] = (pop && in_win && (pop_idx == rd_idx)) ? CNT_W'(1) : '0;
        end
        if (state_q == StSweep) begin
            cnt_d[sweep_idx_q] = '0;
        end
    end

    // Out-of-window tracking; entering a sweep clears it even if a stray code pops that edge.
    always_comb begin
        oow_cnt_d  = oow_cnt_q;
        oow_flag_d = oow_flag_q;
        if (pop && !in_win) begin
            if (oow_cnt_q != 16'hFFFF) oow_cnt_d = oow_cnt_q + 16'd1;
            oow_flag_d = 1'b1;
        end
        if ((state_q == StIdle) && bus.clr_all) begin
            oow_cnt_d  = '0;
            oow_flag_d = 1'b0;
        end
    end

    // Read response: data is the pre-edge counter value, zeroed when rejected or idle.
    always_comb begin
        rd_ack_d  = bus.rd_req;
        rd_err_d  = bus.rd_req && !rd_ok;
        rd_data_d = rd_ok ? cnt_q[rd_idx] : '0;
    end

    // Counter, out-of-window and read response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_CNTR); i++) cnt_q[i] <= '0;
            oow_cnt_q  <= '0;
            oow_flag_q <= 1'b0;
            rd_ack_q   <= 1'b0;
            rd_err_q   <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            cnt_q      <= cnt_d;
            oow_cnt_q  <= oow_cnt_d;
            oow_flag_q <= oow_flag_d;
            rd_ack_q   <= rd_ack_d;
            rd_err_q   <= rd_err_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign bus.evt_ready = evt_ready;
    assign bus.busy      = busy;
    assign bus.rd_ack    = rd_ack_q;
    assign bus.rd_err    = rd_err_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.oow_cnt   = oow_cnt_q;
    assign bus.oow_flag  = oow_flag_q;
endmodule

// File: tb/tb_cr_stats_evt_aggregator.sv
// Randomized bench with a queue-based reference model and a read-response scoreboard.
// A second instance with 3-bit counters sees identical stimulus to exercise saturation.
module tb_cr_stats_evt_aggregator;
    localparam int unsigned NC = 16;
    localparam longint unsigned MAX32 = 64'hFFFF_FFFF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cr_stats_evt_aggregator_if #(.NUM_CNTR(16), .CNT_W(32)) bus ();
    cr_stats_evt_aggregator_if #(.NUM_CNTR(16), .CNT_W(3))  bus_s ();

    assign bus_s.evt_valid = bus.evt_valid;
    assign bus_s.evt_code  = bus.evt_code;
    assign bus_s.clr_all   = bus.clr_all;
    assign bus_s.rd_req    = bus.rd_req;
    assign bus_s.rd_addr   = bus.rd_addr;
    assign bus_s.rd_clr    = bus.rd_clr;

    cr_stats_evt_aggregator u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    cr_stats_evt_aggregator #(.CNT_W(3)) u_dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus_s)
    );

    typedef struct {
        bit              err;
        longint unsigned data;
    } rsp_t;

    rsp_t            exp_q[$];
    int unsigned     m_q[$];
    longint unsigned m_cnt[NC];
    int unsigned     m_sweep;
    int unsigned     m_oow;
    bit              m_flag;
    int              errors = 0;
    int              checks = 0;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < int'(NC); i++) m_cnt[i] = 0;
        m_q.delete();
        m_sweep = 0;
        m_oow   = 0;
        m_flag  = 0;
    endtask

    task automatic drive(input bit v, input int unsigned code, input bit clr,
                         input bit rq, input int unsigned addr, input bit rc);
        bus.evt_valid = v;
        bus.evt_code  = 10'(code);
        bus.clr_all   = clr;
        bus.rd_req    = rq;
        bus.rd_addr   = 5'(addr);
        bus.rd_clr    = rc;
    endtask

    // Called just after a falling edge with inputs already driven; advances one clock.
    task automatic tick();
        bit          ready, pop, rd_valid;
        int          pop_idx;
        bit          pop_oow;
        int unsigned c, a;
        rsp_t        r;
        #1;
        ready = (m_q.size() < 4) && (m_sweep == 0);
        chk("evt_ready", bus.evt_ready, ready);
        chk("busy", bus.busy, m_sweep != 0);
        chk("oow_cnt", bus.oow_cnt, m_oow);
        chk("oow_flag", bus.oow_flag, m_flag);

        pop = (m_sweep == 0) && (m_q.size() > 0);
        pop_idx = -1;
        pop_oow = 0;
        if (pop) begin
            c = m_q.pop_front();
            if (c >= 640 && c < 640 + NC) pop_idx = int'(c - 640);
            else pop_oow = 1;
        end

        a = 32'(bus.rd_addr);
        rd_valid = bus.rd_req && (a < NC) && (m_sweep == 0);
        if (bus.rd_req) begin
            r.err  = !rd_valid;
            r.data = rd_valid ? m_cnt[a] : 0;
            exp_q.push_back(r);
        end

        if (pop_idx >= 0 && m_cnt[pop_idx] < MAX32) m_cnt[pop_idx]++;
        if (pop_oow) begin
            if (m_oow < 16'hFFFF) m_oow++;
            m_flag = 1;
        end
        if (rd_valid && bus.rd_clr) m_cnt[a] = (pop_idx == int'(a)) ? 1 : 0;

        if (m_sweep > 0) begin
            m_cnt[NC - m_sweep] = 0;
            m_sweep--;
        end else if (bus.clr_all) begin
            m_sweep = NC;
            m_oow   = 0;
            m_flag  = 0;
        end

        if (bus.evt_valid && ready) m_q.push_back(32'(bus.evt_code));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 0, 0, 0, 0);
            tick();
        end
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        exp_q.delete();
        model_clear();
        #1;
        chk("rst_evt_ready", bus.evt_ready, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_rd_ack", bus.rd_ack, 0);
        chk("rst_rd_data", bus.rd_data, 0);
        chk("rst_oow_cnt", bus.oow_cnt, 0);
        chk("rst_oow_flag", bus.oow_flag, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Scoreboard monitor: every read issued before an edge must be answered right after it.
    always @(negedge clk) begin
        rsp_t e;
        bit   has_exp;
        longint unsigned sat;
        if (!rst) begin
            has_exp = (exp_q.size() != 0);
            chk("rd_ack", bus.rd_ack, has_exp);
            if (has_exp) begin
                e = exp_q.pop_front();
                sat = (e.data > 7) ? 7 : e.data;
                chk("rd_data", bus.rd_data, e.data);
                chk("rd_err", bus.rd_err, e.err);
                chk("sat_rd_ack", bus_s.rd_ack, 1);
                chk("sat_rd_data", bus_s.rd_data, sat);
            end else begin
                chk("idle_rd_data", bus.rd_data, 0);
                chk("idle_rd_err", bus.rd_err, 0);
            end
        end
    end

    initial begin
        drive(0, 0, 0, 0, 0, 0);
        model_clear();
        @(negedge clk);
        do_reset();

        // Three back-to-back events to counter 2, then read it.
        for (int i = 0; i < 3; i++) begin drive(1, 642, 0, 0, 0, 0); tick(); end
        idle(1);
        drive(0, 0, 0, 1, 2, 0); tick();
        idle(1);

        // Out-of-window code, then read every counter.
        drive(1, 896, 0, 0, 0, 0); tick();
        idle(2);
        for (int i = 0; i < int'(NC); i++) begin drive(0, 0, 0, 1, i, 0); tick(); end
        idle(1);

        // Clear-on-read coinciding with a pop to the same counter.
        for (int i = 0; i < 7; i++) begin drive(1, 640, 0, 0, 0, 0); tick(); end
        idle(1);
        drive(1, 640, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 1, 0, 1); tick();
        idle(1);
        drive(0, 0, 0, 1, 0, 0); tick();

        // Drive counter 5 past the small instance's saturation point.
        for (int i = 0; i < 12; i++) begin drive(1, 645, 0, 0, 0, 0); tick(); end
        idle(1);
        drive(0, 0, 0, 1, 5, 0); tick();

        // Clear-all with events arriving around it and a read during the sweep.
        drive(1, 641, 0, 0, 0, 0); tick();
        drive(1, 643, 1, 1, 3, 0); tick();
        drive(1, 644, 0, 1, 5, 0); tick();
        for (int i = 0; i < 16; i++) begin drive(1, 646, 0, 0, 0, 0); tick(); end
        idle(2);
        for (int i = 0; i < 8; i++) begin drive(0, 0, 0, 1, i, 0); tick(); end

        // Out-of-range read addresses.
        drive(0, 0, 0, 1, 16, 0); tick();
        drive(0, 0, 0, 1, 31, 1); tick();
        idle(1);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            int unsigned code;
            code = ($urandom_range(7) == 0) ? $urandom_range(1023) : 640 + $urandom_range(15);
            drive($urandom_range(3) != 0, code, $urandom_range(149) == 0,
                  $urandom_range(2) == 0, $urandom_range(19), $urandom_range(3) == 0);
            tick();
        end
        idle(20);

        // Reset in the middle of a sweep aborts it.
        drive(1, 650, 0, 0, 0, 0); tick();
        drive(0, 0, 1, 0, 0, 0); tick();
        idle(5);
        do_reset();
        for (int i = 0; i < int'(NC); i++) begin drive(0, 0, 0, 1, i, 0); tick(); end
        idle(2);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
